// File: rtl/opctrl_vc.sv
// Router output controller with two single-flit virtual channels.
// Captures into VC[polarity] and drains VC[~polarity] to the link.
module opctrl_vc #(
  parameter int DATA_W = 64,
  parameter int NUM_IN = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     polarity,
  input  logic [NUM_IN-1:0]        grant,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic                     receive_output,
  output logic [DATA_W-1:0]        data_out,
  output logic                     send_output,
  output logic [1:0]               empty,
  output logic [NUM_IN-1:0]        clear,
  output logic                     grant_err,
  output logic [CNT_W-1:0]         sent_count
);

  logic [DATA_W-1:0] vc0_data_q, vc0_data_d;
  logic [DATA_W-1:0] vc1_data_q, vc1_data_d;
  logic [1:0]        vc_full_q, vc_full_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              send_q, send_d;
  logic [NUM_IN-1:0] clear_q, clear_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              onehot;
  logic              no_grant;
  logic              wr_p;
  logic              rd_q;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) sel_data = sel_data | data_in[i*DATA_W +: DATA_W];
    end
  end

  assign no_grant = (grant == '0);
  assign onehot   = !no_grant &&
                    ((grant & (grant - NUM_IN'(1))) == '0);
  assign wr_p     = polarity;
  assign rd_q     = ~polarity;
  assign rd_data  = rd_q ? vc1_data_q : vc0_data_q;

  always_comb begin
    vc0_data_d = vc0_data_q;
    vc1_data_d = vc1_data_q;
    vc_full_d  = vc_full_q;
    data_out_d = data_out_q;
    send_d     = 1'b0;
    clear_d    = '0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    // write side: VC[polarity]
    unique case (1'b1)
      no_grant: begin
      end
      (onehot && !vc_full_q[wr_p]): begin
        if (wr_p) vc1_data_d = sel_data;
        else      vc0_data_d = sel_data;
        vc_full_d[wr_p] = 1'b1;
        clear_d         = grant;
      end
      default: begin
        err_d = 1'b1;
      end
    endcase

    // read side: VC[~polarity], never the one written above
    if (vc_full_q[rd_q] && receive_output) begin
      data_out_d      = rd_data;
      send_d          = 1'b1;
      vc_full_d[rd_q] = 1'b0;
      cnt_d           = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc0_data_q <= '0;
      vc1_data_q <= '0;
      vc_full_q  <= 2'b00;
      data_out_q <= '0;
      send_q     <= 1'b0;
      clear_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vc0_data_q <= vc0_data_d;
      vc1_data_q <= vc1_data_d;
      vc_full_q  <= vc_full_d;
      data_out_q <= data_out_d;
      send_q     <= send_d;
      clear_q    <= clear_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign empty       = ~vc_full_q;
  assign data_out    = data_out_q;
  assign send_output = send_q;
  assign clear       = clear_q;
  assign grant_err   = err_q;
  assign sent_count  = cnt_q;

endmodule

// File: tb/tb_opctrl_vc.sv
// Scoreboard bench for opctrl_vc: sent flits checked by a monitor,
// control outputs checked inline against hand-computed values.
module tb_opctrl_vc;

  localparam int DW = 64;
  localparam int NI = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            polarity;
  logic [NI-1:0]   grant;
  logic [NI*DW-1:0] data_in;
  logic            receive_output;

  logic [DW-1:0]   data_out, data_out4;
  logic            send_output, send_output4;
  logic [1:0]      empty, empty4;
  logic [NI-1:0]   clear, clear4;
  logic            grant_err, grant_err4;
  logic [15:0]     sent_count;
  logic [3:0]      sent_count4;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q [$];
  logic pol;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  opctrl_vc #(.DATA_W(DW), .NUM_IN(NI), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .grant(grant),
    .data_in(data_in), .receive_output(receive_output),
    .data_out(data_out), .send_output(send_output), .empty(empty),
    .clear(clear), .grant_err(grant_err), .sent_count(sent_count)
  );

  opctrl_vc #(.DATA_W(DW), .NUM_IN(NI), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .polarity(polarity), .grant(grant),
    .data_in(data_in), .receive_output(receive_output),
    .data_out(data_out4), .send_output(send_output4), .empty(empty4),
    .clear(clear4), .grant_err(grant_err4), .sent_count(sent_count4)
  );

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every send must match the head of the scoreboard
  always @(posedge clk) begin
    #2;
    if (send_output === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_send: got %0h expected none", data_out);
      end else begin
        chk("send_data", data_out, exp_q.pop_front());
      end
    end
  end

  // one clock: drive inputs, take edge, sample 2 time units later
  task automatic cyc(input logic [NI-1:0] g, input logic [DW-1:0] d,
                     input logic rcv);
    grant = g;
    receive_output = rcv;
    for (int i = 0; i < NI; i++)
      data_in[i*DW +: DW] = g[i] ? d : (64'hDEAD_0000_0000_0000 | DW'(i));
    polarity = pol;
    @(posedge clk);
    #2;
    pol = ~pol;
    polarity = pol;
  endtask

  task automatic align(input logic p);
    if (pol != p) cyc('0, '0, 1'b0);
  endtask

  task automatic chk_cnt(input string name);
    chk(name, {48'd0, sent_count}, DW'(exp_cnt));
    chk({name, "_w4"}, {60'd0, sent_count4}, DW'(exp_cnt % 16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    pol = 1'b0;
    polarity = 1'b0;
    grant = '0;
    data_in = '0;
    receive_output = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // reset state
    chk("rst_empty", DW'(empty), 64'd3);
    chk("rst_send", DW'(send_output), 64'd0);
    chk("rst_clear", DW'(clear), 64'd0);
    chk("rst_err", DW'(grant_err), 64'd0);
    chk("rst_dout", data_out, 64'd0);
    chk_cnt("rst_cnt");

    // basic path through VC0
    align(1'b0);
    exp_q.push_back(64'hA5A5_0000_0000_0001);
    cyc(5'b00100, 64'hA5A5_0000_0000_0001, 1'b1);
    chk("basic_clear", DW'(clear), 64'h04);
    chk("basic_empty_full", DW'(empty), 64'd2);
    cyc('0, '0, 1'b1);
    exp_cnt = 1;
    chk("basic_send", DW'(send_output), 64'd1);
    chk("basic_clear_off", DW'(clear), 64'd0);
    chk("basic_empty", DW'(empty), 64'd3);
    chk_cnt("basic_cnt");

    // interleaved VCs
    align(1'b0);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd2);
    cyc(5'b00001, 64'd1, 1'b1);
    chk("il_clear0", DW'(clear), 64'h01);
    cyc(5'b10000, 64'd2, 1'b1);
    chk("il_clear1", DW'(clear), 64'h10);
    chk("il_send1", DW'(send_output), 64'd1);
    cyc('0, '0, 1'b1);
    chk("il_send2", DW'(send_output), 64'd1);
    chk("il_clear_off", DW'(clear), 64'd0);
    exp_cnt = 3;
    chk_cnt("il_cnt");

    // backpressure on VC1
    align(1'b1);
    exp_q.push_back(64'h0000_BEEF_0000_0003);
    cyc(5'b01000, 64'h0000_BEEF_0000_0003, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc('0, '0, 1'b0);
      chk("bp_nosend", DW'(send_output), 64'd0);
      chk("bp_held", DW'(empty[1]), 64'd0);
    end
    cyc('0, '0, 1'b1);
    chk("bp_send", DW'(send_output), 64'd1);
    chk("bp_empty", DW'(empty), 64'd3);
    exp_cnt = 4;
    chk_cnt("bp_cnt");

    // non-one-hot grant
    align(1'b0);
    cyc(5'b00110, 64'h77, 1'b1);
    chk("err_multi", DW'(grant_err), 64'd1);
    chk("err_multi_clear", DW'(clear), 64'd0);
    chk("err_multi_empty", DW'(empty), 64'd3);
    cyc('0, '0, 1'b0);
    chk("err_drop", DW'(grant_err), 64'd0);

    // grant into a full VC
    exp_q.push_back(64'h11);
    cyc(5'b00001, 64'h11, 1'b0);
    chk("err_fill_ok", DW'(grant_err), 64'd0);
    cyc('0, '0, 1'b0);
    cyc(5'b00010, 64'h22, 1'b0);
    chk("err_full", DW'(grant_err), 64'd1);
    chk("err_full_clear", DW'(clear), 64'd0);
    chk("err_full_empty", DW'(empty), 64'd2);
    cyc('0, '0, 1'b1);
    exp_cnt = 5;
    chk_cnt("err_cnt");

    // counter wrap: 12 more flits -> 17 total
    align(1'b0);
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back(64'd100 + DW'(k));
      cyc(5'b00001 << (k % 5), 64'd100 + DW'(k), 1'b1);
    end
    cyc('0, '0, 1'b1);
    exp_cnt = 17;
    chk_cnt("wrap_cnt");
    chk("wrap_empty", DW'(empty), 64'd3);
    chk("wrap_err", DW'(grant_err), 64'd0);

    // async reset while VC0 holds a flit
    align(1'b0);
    cyc(5'b00100, 64'hCAFE, 1'b0);
    chk("pre_rst_clear", DW'(clear), 64'h04);
    #1 reset = 1'b1;
    #1;
    chk("arst_empty", DW'(empty), 64'd3);
    chk("arst_send", DW'(send_output), 64'd0);
    chk("arst_clear", DW'(clear), 64'd0);
    chk("arst_cnt", DW'(sent_count), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    exp_cnt = 0;
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    chk("post_rst_empty", DW'(empty), 64'd3);
    chk_cnt("post_rst_cnt");

    chk("sb_drained", DW'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
